// File: rtl/cfg_shift_loader_pkg.sv
// Shared definitions for the serial configuration loader: word size,
// reset word, idle timeout and the loader FSM state type.
package cfg_pkg;

    localparam int                   CFG_WIDTH       = 32;
    localparam int                   CFG_TIMEOUT     = 1024;
    localparam logic [CFG_WIDTH-1:0] CFG_RESET_VALUE = 32'h0000_0001;
    localparam int                   CNT_W           = $clog2(CFG_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/cfg_shift_loader_if.sv
// Committed-configuration bundle from the loader (master) to the downstream
// core (slave): shadow word, commit strobe and loader status.
interface cfg_shift_loader_if #(
    parameter int WIDTH = 32
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] cfg_word;
    logic             cfg_valid;
    logic             loading;
    logic [CW-1:0]    bit_cnt;
    logic             frame_err;

    modport master (
        output cfg_word,
        output cfg_valid,
        output loading,
        output bit_cnt,
        output frame_err
    );

    modport slave (
        input cfg_word,
        input cfg_valid,
        input loading,
        input bit_cnt,
        input frame_err
    );
endinterface

// File: rtl/cfg_shift_loader_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous strobe pin plus LANES data pins,
// with rising-edge detect on the strobe at the same stage the data is taken.
module sync_edge_det #(
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clk_pin,
    input  logic [LANES-1:0] i_data,
    output logic             o_rise,
    output logic [LANES-1:0] o_data
);
    logic [LANES:0] w_pins;
    logic [LANES:0] r_s1;
    logic [LANES:0] r_s2;
    logic           r_s3;

    assign w_pins = {i_data, i_clk_pin};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= w_pins;
            r_s2 <= r_s1;
            r_s3 <= r_s2[0];
        end
    end

    // Data comes from s2 so it lines up with the edge flagged by s2 & ~s3.
    assign o_rise = r_s2[0] & ~r_s3;
    assign o_data = r_s2[LANES:1];

endmodule

// File: rtl/cfg_shift_loader.sv
// Serial configuration loader: MSB-first shift of bit-banged pins into a
// WIDTH-bit word, published atomically through a shadow register.
module cfg_shift_loader
    import cfg_pkg::*;
#(
    parameter int               WIDTH       = CFG_WIDTH,
    parameter int               TIMEOUT     = CFG_TIMEOUT,
    parameter logic [WIDTH-1:0] RESET_VALUE = CFG_RESET_VALUE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_clk,
    input  logic               shift_dta,
    cfg_shift_loader_if.master cfg
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    cfg_state_t       r_state, w_state_next;
    logic [WIDTH-1:0] r_sreg, w_sreg_next;
    logic [CW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic [TW-1:0]    r_tmo, w_tmo_next;
    logic [WIDTH-1:0] r_cfg_word, w_cfg_word_next;
    logic             r_frame_err, w_frame_err_next;

    logic             w_edge;
    logic             w_dta;
    logic [WIDTH-1:0] w_shift;
    logic [CW-1:0]    w_cnt_inc;

    sync_edge_det #(
        .LANES(1)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clk_pin (shift_clk),
        .i_data    (shift_dta),
        .o_rise    (w_edge),
        .o_data    (w_dta)
    );

    assign w_shift = {r_sreg[WIDTH-2:0], w_dta};
    // Outside SHIFT the incoming bit is always the first of a fresh word.
    assign w_cnt_inc = ((r_state == SHIFT) ? r_bit_cnt : '0) + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_tmo       <= '0;
            r_cfg_word  <= RESET_VALUE;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sreg      <= w_sreg_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_tmo       <= w_tmo_next;
            r_cfg_word  <= w_cfg_word_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sreg_next      = r_sreg;
        w_bit_cnt_next   = r_bit_cnt;
        w_tmo_next       = '0;
        w_cfg_word_next  = r_cfg_word;
        w_frame_err_next = r_frame_err;

        if (w_edge) begin
            // An edge always wins, including on the timeout expiry cycle.
            w_sreg_next    = w_shift;
            w_bit_cnt_next = w_cnt_inc;
            if (w_cnt_inc == CNT_FULL) begin
                // Shadow loads on entry so cfg_word and the strobe appear together.
                w_state_next     = COMMIT;
                w_cfg_word_next  = w_shift;
                w_frame_err_next = 1'b0;
            end else begin
                w_state_next = SHIFT;
            end
        end else begin
            case (r_state)
                SHIFT: begin
                    if (r_tmo == TMO_LAST) begin
                        w_state_next     = IDLE;
                        w_sreg_next      = '0;
                        w_bit_cnt_next   = '0;
                        w_frame_err_next = 1'b1;
                    end else begin
                        w_tmo_next = r_tmo + TW'(1);
                    end
                end
                COMMIT: begin
                    w_state_next   = IDLE;
                    w_bit_cnt_next = '0;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_word  = r_cfg_word;
    assign cfg.cfg_valid = (r_state == COMMIT);
    assign cfg.loading   = (r_bit_cnt != '0);
    assign cfg.bit_cnt   = r_bit_cnt;
    assign cfg.frame_err = r_frame_err;

endmodule
